// File: rtl/sram_port_arbiter.sv
// Arbitrates inst-fetch and load/store requesters onto one single-port SRAM; 1 access/cycle, data_ok 1 cycle after addr_ok.
// Data wins conflicts until DATA_STREAK_MAX back-to-back wins. Optional perf counters: define SRAM_ARB_PERF_EN.
module sram_port_arbiter #(
  parameter int DATA_STREAK_MAX = 4,
  parameter int ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_inst_grants,
  output logic [31:0]       perf_data_grants,
  output logic [31:0]       perf_conflicts
`endif
);

  typedef enum logic {OWN_INST, OWN_DATA} owner_t;

  localparam logic [3:0] STREAK_MAX = 4'(DATA_STREAK_MAX);

  logic       r_resp_valid;
  owner_t     r_resp_owner;
  logic       r_resp_store;
  logic [3:0] r_streak_cnt;

  logic w_inst_prio;
  logic w_inst_win;
  logic w_data_win;
  logic w_grant;
  logic w_resp_live;

  // Grants are suppressed while reset is high so the reqs are effectively unsampled.
  assign w_inst_prio = (r_streak_cnt == STREAK_MAX);
  assign w_inst_win  = !reset && inst_req && (!data_req || w_inst_prio);
  assign w_data_win  = !reset && data_req && (!inst_req || !w_inst_prio);
  assign w_grant     = w_inst_win || w_data_win;

  assign inst_addr_ok = w_inst_win;
  assign data_addr_ok = w_data_win;

  assign mem_en    = w_grant;
  assign mem_we    = (w_data_win && data_wr) ? data_wstrb : 4'b0;
  assign mem_addr  = w_data_win ? data_addr : (w_inst_win ? inst_addr : '0);
  assign mem_wdata = w_grant ? data_wdata : 32'b0;

  // A response in flight when reset rises is masked now and cleared at the edge.
  assign w_resp_live  = r_resp_valid && !reset;
  assign inst_data_ok = w_resp_live && (r_resp_owner == OWN_INST);
  assign data_data_ok = w_resp_live && (r_resp_owner == OWN_DATA);
  assign inst_rdata   = inst_data_ok ? mem_rdata : 32'b0;
  assign data_rdata   = (data_data_ok && !r_resp_store) ? mem_rdata : 32'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_resp_owner <= OWN_INST;
      r_resp_store <= 1'b0;
      r_streak_cnt <= 4'd0;
    end else begin
      r_resp_valid <= w_grant;
      r_resp_owner <= w_data_win ? OWN_DATA : OWN_INST;
      r_resp_store <= w_data_win && data_wr;
      if (w_inst_win || !inst_req) begin
        r_streak_cnt <= 4'd0;
      end else if (w_data_win && (r_streak_cnt != STREAK_MAX)) begin
        r_streak_cnt <= r_streak_cnt + 4'd1;
      end
    end
  end

`ifdef SRAM_ARB_PERF_EN
  logic [31:0] r_perf_inst;
  logic [31:0] r_perf_data;
  logic [31:0] r_perf_conf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_inst <= 32'd0;
      r_perf_data <= 32'd0;
      r_perf_conf <= 32'd0;
    end else begin
      if (w_inst_win)            r_perf_inst <= r_perf_inst + 32'd1;
      if (w_data_win)            r_perf_data <= r_perf_data + 32'd1;
      if (inst_req && data_req)  r_perf_conf <= r_perf_conf + 32'd1;
    end
  end

  assign perf_inst_grants = r_perf_inst;
  assign perf_data_grants = r_perf_data;
  assign perf_conflicts   = r_perf_conf;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 1-cycle-latency byte-writable SRAM.
// Inputs change just after negedge; outputs are checked 1 ns later.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
`ifdef SRAM_ARB_PERF_EN
  logic [31:0] perf_inst_grants, perf_data_grants, perf_conflicts;
`endif

  int n_asserts = 0;
  int n_fail    = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  sram_port_arbiter #(.DATA_STREAK_MAX(4), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef SRAM_ARB_PERF_EN
    , .perf_inst_grants(perf_inst_grants), .perf_data_grants(perf_data_grants),
    .perf_conflicts(perf_conflicts)
`endif
  );

  // SRAM model: read returns the pre-write word, word index from addr[9:2]
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem[mem_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".inst_addr_ok"}, {31'b0, inst_addr_ok}, 32'd0);
    chk({tag, ".data_addr_ok"}, {31'b0, data_addr_ok}, 32'd0);
    chk({tag, ".inst_data_ok"}, {31'b0, inst_data_ok}, 32'd0);
    chk({tag, ".data_data_ok"}, {31'b0, data_data_ok}, 32'd0);
    chk({tag, ".inst_rdata"}, inst_rdata, 32'd0);
    chk({tag, ".data_rdata"}, data_rdata, 32'd0);
    chk({tag, ".mem_en"}, {31'b0, mem_en}, 32'd0);
    chk({tag, ".mem_we"}, {28'b0, mem_we}, 32'd0);
    chk({tag, ".mem_addr"}, mem_addr, 32'd0);
    chk({tag, ".mem_wdata"}, mem_wdata, 32'd0);
  endtask

  logic [31:0] exp_b2b [0:4];
  logic [9:0]  exp_inst_win;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | i;
    mem[0]  = 32'h0280_0421;
    mem[64] = 32'h1122_3344;
    exp_b2b[0] = 32'h0280_0421; exp_b2b[1] = 32'h1000_0001; exp_b2b[2] = 32'h1000_0002;
    exp_b2b[3] = 32'h1000_0003; exp_b2b[4] = 32'h1000_0004;
    exp_inst_win = 10'b10_0001_0000;  // bit i: inst wins in conflict cycle i

    // Reset: requests present but nothing granted, all outputs zero
    cyc(); inst_req = 1'b1; data_req = 1'b1; data_addr = 32'h40; #1;
    chk_all_zero("rst");
    cyc(); inst_req = 1'b0; data_req = 1'b0; data_addr = '0; #1;
    chk_all_zero("rst2");
    cyc(); reset = 1'b0; #1;
    chk_all_zero("idle");

    // Single fetch
    cyc(); inst_req = 1'b1; inst_addr = 32'h1c00_0000; #1;
    chk("fetch.addr_ok", {31'b0, inst_addr_ok}, 32'd1);
    chk("fetch.d_addr_ok", {31'b0, data_addr_ok}, 32'd0);
    chk("fetch.mem_en", {31'b0, mem_en}, 32'd1);
    chk("fetch.mem_addr", mem_addr, 32'h1c00_0000);
    chk("fetch.mem_we", {28'b0, mem_we}, 32'd0);
    cyc(); inst_req = 1'b0; inst_addr = '0; #1;
    chk("fetch.data_ok", {31'b0, inst_data_ok}, 32'd1);
    chk("fetch.rdata", inst_rdata, 32'h0280_0421);
    chk("fetch.d_data_ok", {31'b0, data_data_ok}, 32'd0);
    chk("fetch.mem_en_off", {31'b0, mem_en}, 32'd0);

    // Store then load of the same word
    cyc(); data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
    data_addr = 32'h100; data_wdata = 32'hAABB_CCDD; #1;
    chk("st.addr_ok", {31'b0, data_addr_ok}, 32'd1);
    chk("st.mem_we", {28'b0, mem_we}, 32'b0011);
    chk("st.mem_addr", mem_addr, 32'h100);
    chk("st.mem_wdata", mem_wdata, 32'hAABB_CCDD);
    cyc(); data_wr = 1'b0; data_wstrb = 4'b1111; data_wdata = 32'h5555_5555; #1;
    chk("st.data_ok", {31'b0, data_data_ok}, 32'd1);
    chk("st.rdata", data_rdata, 32'd0);
    chk("st.i_data_ok", {31'b0, inst_data_ok}, 32'd0);
    chk("ld.addr_ok", {31'b0, data_addr_ok}, 32'd1);
    chk("ld.mem_we", {28'b0, mem_we}, 32'd0);
    cyc(); data_req = 1'b0; data_addr = '0; data_wstrb = '0; data_wdata = '0; #1;
    chk("ld.data_ok", {31'b0, data_data_ok}, 32'd1);
    chk("ld.rdata", data_rdata, 32'h1122_CCDD);

    // Back-to-back fetches
    for (int i = 0; i < 5; i++) begin
      cyc(); inst_req = 1'b1; inst_addr = 32'(4 * i); #1;
      chk("b2b.addr_ok", {31'b0, inst_addr_ok}, 32'd1);
      chk("b2b.mem_addr", mem_addr, 32'(4 * i));
      if (i == 0) chk("b2b.no_data_ok", {31'b0, inst_data_ok}, 32'd0);
      else begin
        chk("b2b.data_ok", {31'b0, inst_data_ok}, 32'd1);
        chk("b2b.rdata", inst_rdata, exp_b2b[i-1]);
      end
    end
    cyc(); inst_req = 1'b0; inst_addr = '0; #1;
    chk("b2b.last_data_ok", {31'b0, inst_data_ok}, 32'd1);
    chk("b2b.last_rdata", inst_rdata, exp_b2b[4]);

    // Reset while a load is in flight
    cyc(); data_req = 1'b1; data_addr = 32'h200; #1;
    chk("rmf.addr_ok", {31'b0, data_addr_ok}, 32'd1);
    cyc(); data_req = 1'b0; data_addr = '0; reset = 1'b1;
    inst_req = 1'b1; inst_addr = 32'h4; #1;
    chk_all_zero("rmf.in_reset");
    cyc(); reset = 1'b0; inst_req = 1'b0; inst_addr = '0; #1;
    chk("rmf.after1", {31'b0, data_data_ok}, 32'd0);
    cyc(); #1;
    chk("rmf.after2", {31'b0, data_data_ok}, 32'd0);
    chk("rmf.after2_i", {31'b0, inst_data_ok}, 32'd0);

    // Conflict from a fresh reset: D,D,D,D,I,D,D,D,D,I
    cyc(); reset = 1'b1; #1;
    cyc(); reset = 1'b0; #1;
    for (int i = 0; i < 10; i++) begin
      cyc(); inst_req = 1'b1; inst_addr = 32'h40; data_req = 1'b1; data_addr = 32'h200; #1;
      chk("cf.inst_addr_ok", {31'b0, inst_addr_ok}, {31'b0, exp_inst_win[i]});
      chk("cf.data_addr_ok", {31'b0, data_addr_ok}, {31'b0, !exp_inst_win[i]});
      chk("cf.addr_ok_excl", {31'b0, inst_addr_ok & data_addr_ok}, 32'd0);
      chk("cf.mem_addr", mem_addr, exp_inst_win[i] ? 32'h40 : 32'h200);
      if (i > 0) begin
        chk("cf.inst_data_ok", {31'b0, inst_data_ok}, {31'b0, exp_inst_win[i-1]});
        chk("cf.data_data_ok", {31'b0, data_data_ok}, {31'b0, !exp_inst_win[i-1]});
        chk("cf.rdata", inst_rdata | data_rdata,
            exp_inst_win[i-1] ? 32'h1000_0010 : 32'h1000_0080);
      end
    end
    cyc(); inst_req = 1'b0; data_req = 1'b0; inst_addr = '0; data_addr = '0; #1;
    chk("cf.last_inst_ok", {31'b0, inst_data_ok}, 32'd1);
    chk("cf.last_rdata", inst_rdata, 32'h1000_0010);
    chk("cf.last_data_ok", {31'b0, data_data_ok}, 32'd0);
`ifdef SRAM_ARB_PERF_EN
    chk("perf.data", perf_data_grants, 32'd8);
    chk("perf.inst", perf_inst_grants, 32'd2);
    chk("perf.conf", perf_conflicts, 32'd10);
`endif
    cyc(); #1;
    chk_all_zero("end.idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one synchronous single-port SRAM (1-cycle read latency) between the CPU's instruction-fetch requester and its load/store requester.
- Both requesters use a req/addr_ok/data_ok handshake.
- The block arbitrates between them, issues at most one memory access per cycle, and returns each response to the requester that owns it.
- It sits between the CPU core's inst/data SRAM ports and the unified memory macro.

Parameters:
- DATA_STREAK_MAX, 4: maximum consecutive data grants while inst_req is pending; inst wins the next arbitration after this many. Legal range 1..15.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- inst_req  in  1  fetch request, held until inst_addr_ok.
- inst_addr  in  ADDR_W  fetch byte address, word aligned.
- inst_addr_ok  out  1  fetch request accepted this cycle.
- inst_data_ok  out  1  fetch data valid this cycle.
- inst_rdata  out  32  fetch data.
- data_req  in  1  load/store request, held until data_addr_ok.
- data_wr  in  1  1 = store, 0 = load.
- data_wstrb  in  4  byte enables for a store; ignored for a load.
- data_addr  in  ADDR_W  load/store byte address.
- data_wdata  in  32  store data.
- data_addr_ok  out  1  load/store request accepted this cycle.
- data_data_ok  out  1  load data valid, or store complete, this cycle.
- data_rdata  out  32  load data.
- mem_en  out  1  SRAM access this cycle.
- mem_we  out  4  SRAM byte write enables.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_en.

Behaviour:
- Response state: resp_valid (1 bit) and resp_owner (INST or DATA). These form a 1-deep in-flight tracker; there is no other FSM state.
- Grant (combinational, every cycle):
  - If only one req is high, that requester wins.
  - If both are high, data wins unless streak_cnt == DATA_STREAK_MAX, in which case inst wins.
- addr_ok: the winner's addr_ok is asserted combinationally in the same cycle. The loser's addr_ok stays 0 and it keeps req/addr held.
- Memory drive in the grant cycle:
  - mem_en = 1.
  - mem_addr = winner's address.
  - mem_we = data_wstrb if the winner is data and data_wr = 1, else 4'b0.
  - mem_wdata = data_wdata.
  - With no grant: mem_en = 0, mem_we = 0, mem_addr and mem_wdata = 0.
- Response timing:
  - On the clock edge after a grant, resp_valid <= 1 and resp_owner <= winner.
  - In the following cycle the owner's data_ok = 1 and its rdata = mem_rdata.
  - The non-owner's data_ok = 0 and its rdata = 0.
  - A store still produces data_data_ok exactly 1 cycle after its grant; data_rdata is don't-care, driven 0.
- Throughput: a new grant may occur in the same cycle as a data_ok (fully pipelined), giving 1 access per cycle.
- Fixed latency: every accepted request receives its data_ok exactly 1 cycle later. Neither requester can stall a response.
- streak_cnt (4 bits):
  - Increments when data is granted while inst_req = 1; saturates at DATA_STREAK_MAX.
  - Clears to 0 when inst is granted or when inst_req = 0.
- Reset:
  - resp_valid = 0, streak_cnt = 0.
  - Every output is 0, including both addr_ok, both data_ok, both rdata, mem_en, mem_we, mem_addr and mem_wdata.
  - No grant is issued while reset = 1.
  - Reset asserted while a response is in flight: the response is dropped and no data_ok appears after reset deasserts.
- The req signals are sampled only while reset = 0.
- Both addr_ok signals are never high in the same cycle.
- Both data_ok signals are never high in the same cycle.

Optional Feature:
- Macro: SRAM_ARB_PERF_EN.
- Defined: adds three outputs, perf_inst_grants (32 bits), perf_data_grants (32 bits) and perf_conflicts (32 bits).
  - perf_inst_grants and perf_data_grants count grants per requester.
  - perf_conflicts counts cycles where both reqs are high.
  - All three clear on reset and wrap modulo 2^32.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Single fetch: inst_req = 1, addr = 0x1c000000, memory word 0x02800421 → inst_addr_ok = 1 in cycle T, mem_en = 1, mem_addr = 0x1c000000, mem_we = 0; inst_data_ok = 1 with inst_rdata = 0x02800421 at T+1, data_data_ok = 0.
- Store then load: data_req with wr = 1, strb = 4'b0011, addr = 0x100, wdata = 0xAABBCCDD over a word of 0x11223344; then a load of 0x100 → mem_we = 0011 at T; data_data_ok at T+1; the load returns 0x1122CCDD.
- Conflict: both reqs held high continuously, DATA_STREAK_MAX = 4 → grant sequence D,D,D,D,I,D,D,D,D,I,…; never two addr_ok in one cycle; each data_ok goes to the correct owner.
- Back-to-back fetches: inst_req high for 5 cycles with addresses 0x0, 0x4, …, 0x10 → 5 addr_ok in consecutive cycles, 5 data_ok in cycles T+1..T+5 with matching data.
- Reset mid-flight: grant a load at T, assert reset at T+1 → data_data_ok = 0 at T+1 and afterwards; all outputs are 0 during reset.
- With SRAM_ARB_PERF_EN defined, run the conflict test for 10 cycles → perf_data_grants = 8, perf_inst_grants = 2, perf_conflicts = 10.
